// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one signed 32x32 multiplier among NUM_REQ requesters.
// A round-robin arbiter picks one valid request per cycle. Its 64-bit product
// travels through a LAT-stage stallable pipeline, tagged with the requester
// index, and is returned on a single valid/ready response port in accept order.

module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int LAT     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [63:0]            rsp_z,
    input  logic                   flush,
    output logic                   busy,
    output logic [31:0]            op_count
);

    // Pipeline stage registers; index 0 is stage 1, index LAT-1 drives the response
    logic [LAT-1:0]  stg_valid_r;
    logic [IDW-1:0]  stg_id_r [LAT];
    logic [63:0]     stg_z_r  [LAT];

    logic [IDW-1:0]  rr_ptr_r;
    logic [31:0]     op_count_r;

    logic            stall_s;
    logic            grant_found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW:0]    cand_sum_s;
    logic [IDW-1:0]  cand_idx_s;
    logic            accept_s;
    logic [NUM_REQ-1:0] ready_s;

    logic [31:0]        a_arr_s [NUM_REQ];
    logic [31:0]        b_arr_s [NUM_REQ];
    logic signed [31:0] a_sel_s;
    logic signed [31:0] b_sel_s;
    logic signed [63:0] prod_s;

    // Unpack the flat operand buses into per-requester words
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr_s[gi] = req_a[32*gi +: 32];
        assign b_arr_s[gi] = req_b[32*gi +: 32];
    end

    // A held response freezes the whole pipeline
    assign stall_s = stg_valid_r[LAT-1] & ~rsp_ready;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = '0;
        cand_idx_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (cand_sum_s >= (IDW+1)'(NUM_REQ)) begin
                cand_sum_s = cand_sum_s - (IDW+1)'(NUM_REQ);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_idx_s = cand_sum_s[IDW-1:0];
            if (!grant_found_s && req_valid[cand_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Ready is one-hot on the granted requester, suppressed by stall, reset and flush
    always_comb begin
        ready_s  = {NUM_REQ{1'b0}};
        accept_s = grant_found_s & ~stall_s & ~rst & ~flush;
        if (accept_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    assign req_ready = ready_s;

    // Granted operands feed the shared multiplier (exact two's-complement product)
    assign a_sel_s = a_arr_s[grant_idx_s];
    assign b_sel_s = b_arr_s[grant_idx_s];
    assign prod_s  = 64'(a_sel_s) * 64'(b_sel_s);

    // Product pipeline: load stage 1 on accept, shift when not stalled, clear on reset/flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stg_valid_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                stg_id_r[i] <= '0;
                stg_z_r[i]  <= 64'd0;
            end
        end else if (!stall_s) begin
            stg_valid_r[0] <= accept_s;
            if (accept_s) begin
                stg_id_r[0] <= grant_idx_s;
                stg_z_r[0]  <= prod_s;
            end else begin
                stg_id_r[0] <= '0;
                stg_z_r[0]  <= 64'd0;
            end
            for (int i = 1; i < LAT; i++) begin
                stg_valid_r[i] <= stg_valid_r[i-1];
                stg_id_r[i]    <= stg_id_r[i-1];
                stg_z_r[i]     <= stg_z_r[i-1];
            end
        end else begin
            stg_valid_r <= stg_valid_r;
        end
    end

    // Arbiter pointer and accepted-op counter advance only on an accept
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r   <= '0;
            op_count_r <= 32'd0;
        end else if (accept_s) begin
            rr_ptr_r   <= (grant_idx_s == IDW'(NUM_REQ-1)) ? '0 : grant_idx_s + IDW'(1);
            op_count_r <= op_count_r + 32'd1;
        end else begin
            rr_ptr_r   <= rr_ptr_r;
            op_count_r <= op_count_r;
        end
    end

    assign rsp_valid = stg_valid_r[LAT-1];
    assign rsp_id    = stg_id_r[LAT-1];
    assign rsp_z     = stg_z_r[LAT-1];
    assign busy      = |stg_valid_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: an in-order queue model with age tags predicts
// every output each cycle; directed scenarios add hand-computed literal checks.

module tb_mult_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int LAT     = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         rsp_ready;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_z;
    logic         busy;
    logic [31:0]  op_count;

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .flush(flush), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          id;
        logic [63:0] z;
        int          tag;
    } item_t;

    // Model: queue of accepted products in order; an item reaches the output
    // after LAT unstalled edges, counted by m_adv.
    item_t       mq[$];
    int          m_ptr;
    int          m_adv;
    logic [31:0] m_cnt;
    bit          auto_drop;

    int          got_id[$];
    logic [63:0] got_z[$];
    int          grant_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int q_at(input int idx);
        if (idx < grant_log.size()) return grant_log[idx];
        return -1;
    endfunction

    function automatic int id_at(input int idx);
        if (idx < got_id.size()) return got_id[idx];
        return -1;
    endfunction

    function automatic logic [63:0] z_at(input int idx);
        if (idx < got_z.size()) return got_z[idx];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]    = 1'b1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic clear_logs();
        got_id.delete();
        got_z.delete();
        grant_log.delete();
    endtask

    // One clock cycle: compare at negedge, then advance the model across the posedge
    task automatic step();
        int          g;
        int          j;
        bit          exp_rv;
        bit          stall;
        bit          acc;
        int          eid;
        logic [63:0] ez;
        logic [3:0]  exp_rdy;
        logic [31:0] opa;
        logic [31:0] opb;
        item_t       it;
        @(negedge clk);
        exp_rv = (mq.size() > 0) && (m_adv - mq[0].tag == LAT);
        eid    = exp_rv ? mq[0].id : 0;
        ez     = exp_rv ? mq[0].z : 64'd0;
        stall  = exp_rv && !rsp_ready;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (m_ptr + k) % NUM_REQ;
            if (g < 0 && req_valid[j]) g = j;
        end
        acc = (g >= 0) && !stall && !rst && !flush;
        exp_rdy = 4'b0000;
        if (acc) exp_rdy[g] = 1'b1;
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_rv});
        chk("rsp_id",    {62'd0, rsp_id},    64'(eid));
        chk("rsp_z",     rsp_z,              ez);
        chk("busy",      {63'd0, busy},      {63'd0, mq.size() > 0});
        chk("op_count",  {32'd0, op_count},  {32'd0, m_cnt});
        chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        if (rsp_valid && rsp_ready) begin
            got_id.push_back(int'(rsp_id));
            got_z.push_back(rsp_z);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
        end
        if (acc) begin
            opa  = req_a[32*g +: 32];
            opb  = req_b[32*g +: 32];
            it.id  = g;
            it.z   = longint'(int'(opa)) * longint'(int'(opb));
            it.tag = m_adv;
        end
        if (rst) begin
            mq.delete();
            m_ptr = 0;
            m_adv = 0;
            m_cnt = 32'd0;
        end else if (flush) begin
            mq.delete();
        end else if (!stall) begin
            if (exp_rv && rsp_ready) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(it);
                m_ptr = (g + 1) % NUM_REQ;
                m_cnt = m_cnt + 32'd1;
            end
            m_adv++;
        end
        @(posedge clk);
        #1;
        if (acc && auto_drop) req_valid[g] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
        req_valid = 4'b0; req_a = 128'd0; req_b = 128'd0;
        auto_drop = 1'b1;
        m_ptr = 0; m_adv = 0; m_cnt = 32'd0;
        step(); step();
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_op_count",  {32'd0, op_count},  64'd0);
        chk("reset_busy",      {63'd0, busy},      64'd0);
        rst = 1'b0;

        // Single op: 7 * -3
        set_req(0, 32'd7, 32'hFFFF_FFFD);
        step();
        step();
        chk("single_valid", {63'd0, rsp_valid}, 64'd1);
        chk("single_id",    {62'd0, rsp_id},    64'd0);
        chk("single_z",     rsp_z,              64'hFFFF_FFFF_FFFF_FFEB);
        chk("single_count", {32'd0, op_count},  64'd1);
        step(); step();

        // Fairness from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        clear_logs();
        auto_drop = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i + 1), 32'(10 * (i + 1)));
        for (int c = 0; c < 8; c++) step();
        req_valid = 4'b0;
        auto_drop = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 8; i++) begin
            chk("fair_grant", 64'(q_at(i)),  64'(i % 4));
            chk("fair_rspid", 64'(id_at(i)), 64'(i % 4));
        end

        // Backpressure: three accepts, then five held cycles with a waiting requester
        clear_logs();
        set_req(0, 32'd2, 32'd3);
        set_req(1, 32'hFFFF_FFFB, 32'd4);
        set_req(2, 32'd100000, 32'd100000);
        set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(); step(); step();
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_id",    {62'd0, rsp_id},    64'd1);
            chk("bp_z",     rsp_z,              64'hFFFF_FFFF_FFFF_FFEC);
            chk("bp_ready", {60'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("bp_count", 64'(got_id.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("bp_order", 64'(id_at(i)), 64'(i));
        chk("bp_z2", z_at(2), 64'h0000_0002_540B_E400);
        chk("bp_z3", z_at(3), 64'd1);

        // Arithmetic corners
        clear_logs();
        set_req(0, 32'h8000_0000, 32'h8000_0000);
        set_req(1, 32'h8000_0000, 32'd1);
        set_req(2, 32'd0, 32'hFFFF_FFFF);
        for (int c = 0; c < 6; c++) step();
        chk("corner_min_min", z_at(0), 64'h4000_0000_0000_0000);
        chk("corner_min_one", z_at(1), 64'hFFFF_FFFF_8000_0000);
        chk("corner_zero",    z_at(2), 64'd0);

        // Flush with two in flight while the output is held
        clear_logs();
        set_req(0, 32'd11, 32'd12);
        set_req(1, 32'd13, 32'd14);
        step(); step();
        rsp_ready = 1'b0;
        flush = 1'b1;
        set_req(2, 32'd5, 32'd6);
        step();
        flush = 1'b0;
        rsp_ready = 1'b1;
        chk("flush_busy",  {63'd0, busy},      64'd0);
        chk("flush_valid", {63'd0, rsp_valid}, 64'd0);
        chk("flush_count", {32'd0, op_count},  64'd17);
        for (int c = 0; c < 4; c++) step();
        chk("flush_nresp", 64'(got_id.size()), 64'd1);
        chk("flush_id",    64'(id_at(0)),      64'd2);
        chk("flush_z",     z_at(0),            64'd30);

        // Reset with LAT ops in flight
        set_req(1, 32'd3, 32'd3);
        set_req(3, 32'd4, 32'd4);
        step(); step();
        clear_logs();
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req(2, 32'd6, 32'd7);
        set_req(3, 32'd8, 32'd9);
        step();
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_id",    {62'd0, rsp_id},    64'd0);
        chk("rst_z",     rsp_z,              64'd0);
        chk("rst_busy",  {63'd0, busy},      64'd0);
        chk("rst_count", {32'd0, op_count},  64'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("rst_first_grant", 64'(q_at(0)),  64'd2);
        chk("rst_second_grant", 64'(q_at(1)), 64'd3);
        chk("rst_nresp", 64'(got_id.size()),  64'd2);
        chk("rst_resp0", z_at(0), 64'd42);
        chk("rst_resp1", z_at(1), 64'd72);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
